lcd_text_driver: RTL and testbench



---
 rtl/lcd_text_driver.sv | 177 +++++++++++++++++
 tb/tb_lcd_text_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-up wait, fixed init sequence, then continuous
// refresh of a per-frame snapshot of line1/line2 or line3/line4.
module lcd_text_driver #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned EN_CYC      = 25,
  parameter int unsigned CMD_CYC     = 2500,
  parameter int unsigned CLR_CYC     = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  input  logic [127:0] line3,
  input  logic [127:0] line4,
  input  logic         page_sel,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         ready,
  output logic         frame_done
);

  localparam int unsigned MAX_AB  = (POWERUP_CYC > EN_CYC) ? POWERUP_CYC : EN_CYC;
  localparam int unsigned MAX_CD  = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  typedef enum logic [1:0] {PWRUP, INIT, FRAME_START, FRAME} top_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} wr_t;

  top_t           top_q, top_d;
  wr_t            wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     idx_q, idx_d;
  logic           ready_q, ready_d;
  logic           fd_q, fd_d;
  logic [127:0]   snap_a_q, snap_a_d;
  logic [127:0]   snap_b_q, snap_b_d;

  logic           in_write;
  logic [CW-1:0]  hold_last;
  logic [3:0]     col_a, col_b;
  logic [7:0]     raw, cur_data;
  logic           cur_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q    <= PWRUP;
      wr_q     <= SETUP;
      cnt_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      fd_q     <= 1'b0;
      snap_a_q <= '0;
      snap_b_q <= '0;
    end else begin
      top_q    <= top_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      fd_q     <= fd_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
    end
  end

  assign in_write  = (top_q == INIT) || (top_q == FRAME);
  assign hold_last = (top_q == INIT && idx_q == 6'd3) ? CLR_LAST : CMD_LAST;

  // Byte for the current sequence index; constant for the whole write, so the
  // bus stays stable from SETUP through HOLD without an extra register.
  always_comb begin
    col_a    = 4'(idx_q - 6'd1);
    col_b    = 4'(idx_q - 6'd18);
    raw      = 8'h00;
    cur_data = 8'h00;
    cur_rs   = 1'b0;
    if (top_q == INIT) begin
      case (idx_q[1:0])
        2'd0:    cur_data = 8'h38;
        2'd1:    cur_data = 8'h0C;
        2'd2:    cur_data = 8'h06;
        default: cur_data = 8'h01;
      endcase
    end else if (top_q == FRAME) begin
      if (idx_q == 6'd0) begin
        cur_data = 8'h80;
      end else if (idx_q == 6'd17) begin
        cur_data = 8'hC0;
      end else begin
        raw      = (idx_q < 6'd17) ? snap_a_q[{~col_a, 3'b000} +: 8]
                                   : snap_b_q[{~col_b, 3'b000} +: 8];
        cur_data = (raw == 8'h00) ? 8'h20 : raw;
        cur_rs   = 1'b1;
      end
    end
  end

  always_comb begin
    top_d    = top_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ready_d  = ready_q;
    fd_d     = 1'b0;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    case (top_q)
      PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          top_d = INIT;
          wr_d  = SETUP;
          cnt_d = '0;
          idx_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRAME_START: begin
        snap_a_d = page_sel ? line3 : line1;
        snap_b_d = page_sel ? line4 : line2;
        top_d    = FRAME;
        wr_d     = SETUP;
        cnt_d    = '0;
        idx_d    = '0;
      end
      default: begin
        case (wr_q)
          SETUP: begin
            wr_d  = PULSE;
            cnt_d = '0;
          end
          PULSE: begin
            if (cnt_q == EN_LAST) begin
              wr_d  = HOLD;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            if (cnt_q == hold_last) begin
              wr_d  = SETUP;
              cnt_d = '0;
              if (top_q == INIT && idx_q == 6'd3) begin
                top_d   = FRAME_START;
                ready_d = 1'b1;
              end else if (top_q == FRAME && idx_q == 6'd33) begin
                top_d = FRAME_START;
                fd_d  = 1'b1;
              end else begin
                idx_d = idx_q + 6'd1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  assign lcd_data   = cur_data;
  assign lcd_rs     = cur_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = in_write && (wr_q == PULSE);
  assign ready      = ready_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: per-cycle timeline model derived from write costs,
// plus literal checks on captured byte streams and key event counts.
module tb_lcd_text_driver;

  localparam int P   = 10;
  localparam int EN  = 2;
  localparam int CMD = 4;
  localparam int CLR = 8;
  localparam int W        = 1 + EN + CMD;
  localparam int WC       = 1 + EN + CLR;
  localparam int INIT_END = P + 3 * W + WC;
  localparam int FP       = 1 + 34 * W;
  localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  localparam logic [8:0] EXP_INIT  [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] line1, line2, line3, line4;
  logic         page_sel;
  logic [7:0]   lcd_data;
  logic         lcd_rs, lcd_rw, lcd_en, ready, frame_done;

  lcd_text_driver #(
    .POWERUP_CYC(P),
    .EN_CYC(EN),
    .CMD_CYC(CMD),
    .CLR_CYC(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .line1(line1), .line2(line2), .line3(line3), .line4(line4),
    .page_sel(page_sel),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .ready(ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at count %0d", name, act, exp, cyc + 1);
    end
  endtask

  function automatic logic [7:0] shown(input logic [7:0] b);
    return (b == 8'h00) ? 8'h20 : b;
  endfunction

  logic [8:0] fb [34];
  logic [8:0] cap [$];
  int   en_rise = -1, rdy_rise = -1, fd_first = -1, fd_cnt = 0;
  logic prev_en = 1'b0, prev_rdy = 1'b0;
  int   c, o, w, ph, f, k, pos;
  logic e_en, e_rdy, e_fd, in_wr;
  logic [8:0] e_wr;

  // Count c = interval after (c-1) rising edges since release.
  always @(negedge clk) begin
    c = cyc + 1;
    e_en = 1'b0; e_rdy = 1'b0; e_fd = 1'b0; in_wr = 1'b1; e_wr = 9'h000;
    if (rst_n && c > P) begin
      if (c <= INIT_END) begin
        o = c - P - 1;
        if (o < 3 * W) begin w = o / W; ph = o % W; end
        else begin w = 3; ph = o - 3 * W; end
        e_wr = {1'b0, INIT_CMDS[w]};
        e_en = (ph >= 1 && ph <= EN);
      end else begin
        e_rdy = 1'b1;
        f = c - INIT_END - 1;
        k = f / FP;
        pos = f % FP;
        if (pos == 0) begin
          e_fd  = (k > 0);
          in_wr = 1'b0;
          fb[0]  = 9'h080;
          fb[17] = 9'h0C0;
          for (int j = 0; j < 16; j++) begin
            fb[1 + j]  = {1'b1, shown(page_sel ? line3[127 - 8 * j -: 8] : line1[127 - 8 * j -: 8])};
            fb[18 + j] = {1'b1, shown(page_sel ? line4[127 - 8 * j -: 8] : line2[127 - 8 * j -: 8])};
          end
        end else begin
          w  = (pos - 1) / W;
          ph = (pos - 1) % W;
          e_wr = fb[w];
          e_en = (ph >= 1 && ph <= EN);
        end
      end
    end
    chk("lcd_en", lcd_en, e_en);
    chk("ready", ready, e_rdy);
    chk("frame_done", frame_done, e_fd);
    chk("lcd_rw", lcd_rw, 0);
    if (in_wr) begin
      chk("lcd_data", lcd_data, e_wr[7:0]);
      chk("lcd_rs", lcd_rs, e_wr[8]);
    end
    if (!rst_n) begin
      prev_en = 1'b0; prev_rdy = 1'b0;
      en_rise = -1; rdy_rise = -1; fd_first = -1; fd_cnt = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        cap.push_back({lcd_rs, lcd_data});
        if (en_rise < 0) en_rise = c;
      end
      if (ready && !prev_rdy && rdy_rise < 0) rdy_rise = c;
      if (frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = c;
      end
      prev_en  = lcd_en;
      prev_rdy = ready;
    end
  end

  task automatic wait_until(input int target);
    while (cyc + 1 < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [8:0] f1 [34];

  initial begin
    page_sel = 1'b0;
    line1 = {24'h414444, 104'h0};
    line2 = {16{8'h41}};
    line3 = {16{8'h53}};
    line4 = {32'h52313D30, 96'h0};
    f1[0] = 9'h080; f1[1] = 9'h141; f1[2] = 9'h144; f1[3] = 9'h144;
    for (int i = 4; i < 17; i++) f1[i] = 9'h120;
    f1[17] = 9'h0C0;
    for (int i = 18; i < 34; i++) f1[i] = 9'h141;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_until(290);
    chk("first_en_rise", en_rise, 12);
    chk("ready_rise", rdy_rise, 43);
    chk("first_frame_done", fd_first, 282);
    chk("frame_done_count", fd_cnt, 1);
    chk("cap_len_frame1", cap.size() >= 38, 1);
    for (int i = 0; i < 4; i++) chk("init_cmd", cap[i], EXP_INIT[i]);
    for (int i = 0; i < 34; i++) chk("frame1_byte", cap[4 + i], f1[i]);

    wait_until(300);
    page_sel = 1'b1;
    wait_until(600);
    line3 = {16{8'h4D}};
    wait_until(1036);
    chk("en_mid_pulse", lcd_en, 1);
    chk("cap_len_frame5", cap.size(), 145);
    chk("f2_line1_col0", cap[39], 9'h141);
    chk("f2_line2_col0", cap[56], 9'h141);
    chk("f3_line3_old", cap[73], 9'h153);
    chk("f3_cmd_c0", cap[89], 9'h0C0);
    chk("f3_line4_col0", cap[90], 9'h152);
    chk("f3_line4_pad", cap[94], 9'h120);
    chk("f4_line3_new", cap[107], 9'h14D);

    rst_n = 1'b0;
    #1;
    chk("rst_lcd_en", lcd_en, 0);
    chk("rst_ready", ready, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    cap.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_until(60);
    chk("reinit_en_rise", en_rise, 12);
    chk("reinit_ready_rise", rdy_rise, 43);
    for (int i = 0; i < 4; i++) chk("reinit_cmd", cap[i], EXP_INIT[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
